// File: rtl/axis_combiner_n.sv
// ---------------------------------------------------------------------------
// axis_combiner_n
//
// N-input AXI-Stream round-robin combiner. Fixed-size bursts are taken from
// each input channel in ascending channel order and merged into one output
// stream. A channel whose burst-length field is zero is skipped. Each output
// word carries the index of its source channel and an end-of-round flag.
// The output goes through a two-entry registered stage (main + skid). This
// stage sustains one word per cycle, and input_ready never depends
// combinationally on output_ready.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   input_valid    in   [CHANNELS]            per-channel valid
//   input_data     in   [CHANNELS*DATA_WIDTH] channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   input_ready    out  [CHANNELS]            per-channel ready
//   output_valid   out  output word valid
//   output_data    out  [DATA_WIDTH]          output word
//   output_channel out  [CH_WIDTH]            source channel of the word
//   output_last    out  final word of a complete round
//   output_ready   in   downstream ready
// ---------------------------------------------------------------------------
module axis_combiner_n #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS = 3,
  parameter int COUNT_WIDTH = 8,
  parameter logic [CHANNELS*COUNT_WIDTH-1:0] CHANNEL_COUNTS = 24'h030102,
  // Derived from CHANNELS; leave at its default.
  parameter int CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            input_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] input_data,
  output logic [CHANNELS-1:0]            input_ready,
  output logic                           output_valid,
  output logic [DATA_WIDTH-1:0]          output_data,
  output logic [CH_WIDTH-1:0]            output_channel,
  output logic                           output_last,
  input  logic                           output_ready
);

  // -------------------------------------------------------------------------
  // Elaboration-time helpers over the packed burst-length table
  // -------------------------------------------------------------------------
  function automatic logic [COUNT_WIDTH-1:0] count_of(input int ch);
    return CHANNEL_COUNTS[ch*COUNT_WIDTH +: COUNT_WIDTH];
  endfunction

  function automatic int first_nz();
    int r;
    r = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (count_of(k) != '0) r = k;
    end
    return r;
  endfunction

  function automatic bit any_nz();
    bit r;
    r = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (count_of(k) != '0) r = 1'b1;
    end
    return r;
  endfunction

  // This function returns the next nonzero channel after ch in wrap-around
  // order. If no other channel is nonzero, it returns ch itself.
  function automatic int next_nz(input int ch);
    int r;
    r = ch;
    // The loop descends, so the smallest forward distance is kept last.
    for (int k = CHANNELS - 1; k >= 1; k--) begin
      if (count_of((ch + k) % CHANNELS) != '0) r = (ch + k) % CHANNELS;
    end
    return r;
  endfunction

  localparam logic [CH_WIDTH-1:0] FIRST_CH = CH_WIDTH'(first_nz());
  localparam bit                  ANY_NZ   = any_nz();

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CH_WIDTH-1:0]    cur_ch_q, cur_ch_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                  valid_m_q, valid_m_d;
  logic [DATA_WIDTH-1:0] data_m_q, data_m_d;
  logic [CH_WIDTH-1:0]   ch_m_q, ch_m_d;
  logic                  last_m_q, last_m_d;

  logic                  valid_s_q, valid_s_d;
  logic [DATA_WIDTH-1:0] data_s_q, data_s_d;
  logic [CH_WIDTH-1:0]   ch_s_q, ch_s_d;
  logic                  last_s_q, last_s_d;

  // -------------------------------------------------------------------------
  // Per-channel constant tables and ready decode
  // -------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] last_cnt [CHANNELS];  // burst length minus one
  logic [CH_WIDTH-1:0]    next_ch  [CHANNELS];
  logic [CHANNELS-1:0]    wraps;                // next nonzero channel is at or below this one
  logic                   accept_ok;

  // Because skid occupancy gates ready, output_ready stays out of this path.
  assign accept_ok = !valid_s_q && rst && ANY_NZ;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    localparam int NXT = next_nz(gi);
    assign last_cnt[gi]    = count_of(gi) - 1'b1;
    assign next_ch[gi]     = CH_WIDTH'(NXT);
    assign wraps[gi]       = (NXT <= gi);
    assign input_ready[gi] = (cur_ch_q == CH_WIDTH'(gi)) && accept_ok;
  end

  // -------------------------------------------------------------------------
  // Current-channel select
  // -------------------------------------------------------------------------
  logic                   sel_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [COUNT_WIDTH-1:0] sel_last_cnt;
  logic [CH_WIDTH-1:0]    sel_next;
  logic                   sel_wrap;

  always_comb begin
    sel_valid    = 1'b0;
    sel_data     = '0;
    sel_last_cnt = '0;
    sel_next     = '0;
    sel_wrap     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cur_ch_q == CH_WIDTH'(i)) begin
        sel_valid    = input_valid[i];
        sel_data     = input_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last_cnt = last_cnt[i];
        sel_next     = next_ch[i];
        sel_wrap     = wraps[i];
      end
    end
  end

  logic xfer;
  logic burst_end;
  logic in_last;
  logic out_hs;

  assign xfer      = sel_valid && accept_ok;
  assign burst_end = (cnt_q == sel_last_cnt);
  assign in_last   = burst_end && sel_wrap;
  assign out_hs    = valid_m_q && output_ready;

  // -------------------------------------------------------------------------
  // Next-state logic: burst sequencing and main/skid output stage
  // -------------------------------------------------------------------------
  always_comb begin
    cur_ch_d  = cur_ch_q;
    cnt_d     = cnt_q;
    valid_m_d = valid_m_q;
    data_m_d  = data_m_q;
    ch_m_d    = ch_m_q;
    last_m_d  = last_m_q;
    valid_s_d = valid_s_q;
    data_s_d  = data_s_q;
    ch_s_d    = ch_s_q;
    last_s_d  = last_s_q;

    if (xfer) begin
      if (burst_end) begin
        cnt_d    = '0;
        cur_ch_d = sel_next;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!valid_m_q || out_hs) begin
      // The main register is free this cycle. A parked skid word takes
      // priority. The skid cannot be full while xfer is high, because ready
      // is low then.
      if (valid_s_q) begin
        valid_m_d = 1'b1;
        data_m_d  = data_s_q;
        ch_m_d    = ch_s_q;
        last_m_d  = last_s_q;
        valid_s_d = 1'b0;
      end else begin
        valid_m_d = xfer;
        if (xfer) begin
          data_m_d = sel_data;
          ch_m_d   = cur_ch_q;
          last_m_d = in_last;
        end
      end
    end else if (xfer) begin
      valid_s_d = 1'b1;
      data_s_d  = sel_data;
      ch_s_d    = cur_ch_q;
      last_s_d  = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch_q  <= FIRST_CH;
      cnt_q     <= '0;
      valid_m_q <= 1'b0;
      data_m_q  <= '0;
      ch_m_q    <= '0;
      last_m_q  <= 1'b0;
      valid_s_q <= 1'b0;
      data_s_q  <= '0;
      ch_s_q    <= '0;
      last_s_q  <= 1'b0;
    end else begin
      cur_ch_q  <= cur_ch_d;
      cnt_q     <= cnt_d;
      valid_m_q <= valid_m_d;
      data_m_q  <= data_m_d;
      ch_m_q    <= ch_m_d;
      last_m_q  <= last_m_d;
      valid_s_q <= valid_s_d;
      data_s_q  <= data_s_d;
      ch_s_q    <= ch_s_d;
      last_s_q  <= last_s_d;
    end
  end

  assign output_valid   = valid_m_q;
  assign output_data    = data_m_q;
  assign output_channel = ch_m_q;
  assign output_last    = last_m_q;

endmodule

// File: doc/axis_combiner_n.md
Name: axis_combiner_n

Overview:
- N-input AXI-Stream round-robin combiner. It interleaves fixed-size bursts from CHANNELS input streams into one output stream, in channel order.
- It is the successor of the 2-input combiner:
  - arbitrary channel count
  - per-channel burst length set by parameter, with zero meaning the channel is skipped
  - output tagged with the source channel and an end-of-round flag
  - registered, full-throughput output stage
- It sits between parallel producers (per-band predictors or coders) and a single serial consumer.

Parameters:
- DATA_WIDTH, 16: width of each data word.
- CHANNELS, 3: number of input streams; must be ≥1.
- COUNT_WIDTH, 8: width of each burst-length field.
- CHANNEL_COUNTS, 24'h030102: packed burst lengths. Field i is bits [i*COUNT_WIDTH +: COUNT_WIDTH]. The default gives ch0=2, ch1=1, ch2=3. A field of 0 skips that channel.
- CH_WIDTH, max(1,$clog2(CHANNELS)): width of output_channel. This is derived and must not be overridden.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-low reset (asserted when 0).
- input_valid, in, CHANNELS: per-channel valid.
- input_data, in, CHANNELS*DATA_WIDTH: channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- input_ready, out, CHANNELS: per-channel ready.
- output_valid, out, 1: output word valid.
- output_data, out, DATA_WIDTH: output word.
- output_channel, out, CH_WIDTH: index of the channel the word came from.
- output_last, out, 1: high on the final word of a complete round.
- output_ready, in, 1: downstream ready.

Behaviour:

State:
- cur_ch: current channel, CH_WIDTH bits.
- cnt: words taken from cur_ch in this burst, COUNT_WIDTH bits.
- Two-entry output stage: main register (valid_m) and skid register (valid_s).

Reset (rst=0, asynchronous):
- cur_ch = lowest channel with a nonzero count; 0 if all counts are zero.
- cnt = 0.
- valid_m = valid_s = 0, so output_valid = 0.
- output_data, output_channel and output_last all = 0.
- input_ready = all 0.
- Release of reset is sampled synchronously; the first transfer can occur on the first rising edge with rst=1.

Input side:
- input_ready[i] = (i == cur_ch) && !valid_s && (rst == 1) && (any count nonzero).
- Every other channel sees ready = 0.
- A transfer happens when input_valid[cur_ch] && input_ready[cur_ch].
- Valid/ready obey AXIS rules: input ready never depends combinationally on output_ready (it is registered through valid_s), and valid must not depend on ready.

On each transfer:
- If cnt == CHANNEL_COUNTS[cur_ch]-1: cnt ← 0 and cur_ch ← next channel after cur_ch, in wrap-around order, whose count is nonzero. If cur_ch is the only nonzero channel, cur_ch stays the same.
- Otherwise cnt ← cnt+1.
- The tag output_last = 1 when this transfer ends the burst AND the next nonzero channel is at or below cur_ch, i.e. the round wraps.

Output stage (standard skid buffer):
- A transferred word goes to the main register if it is empty or draining this cycle; otherwise it goes to the skid register.
- On output handshake, if the skid register is full, its word moves to main.
- Latency from input handshake to output_valid is exactly 1 cycle.
- Sustained throughput is 1 word/cycle while output_ready=1.
- Data, channel and last are held stable while output_valid=1 and output_ready=0.

Boundary conditions:
- All counts zero: input_ready stays 0 forever and output_valid stays 0.
- Count field = 2^COUNT_WIDTH-1: cnt must reach that value without overflow.
- CHANNELS=1: behaves as a registered passthrough. output_last=1 on every COUNTS[0]-th word.
- Backpressure with both stage registers full: input_ready drops. No word is lost or duplicated.
- Reset mid-burst: the partial burst is discarded, any buffered words are dropped, and ordering restarts from the first nonzero channel.
- Simultaneous input and output handshake with skid empty: main is replaced and the occupancy is unchanged.

Test Plan:
- Default counts, all valids high, output_ready=1. Each source emits an increasing sequence. Output channel sequence must be 0,0,1,2,2,2,0,0,… with output_last=1 on every 6th word, one word per cycle after the first-cycle latency.
- CHANNEL_COUNTS=24'h020003, so ch1 is skipped. Sequence must be 0,0,0,2,2 repeating. input_ready[1] must never assert. output_last must be on the ch2 second word.
- Default counts with output_ready low for 5 cycles mid-burst. Input_ready drops at most 2 words after the stall begins. Output data stays stable. The order after resume is identical to the no-stall case, with no gaps or duplicates.
- Only ch2 valid for its whole burst while cur_ch=0. The combiner waits: output_valid=0 and ch2 is not served early. Order resumes correctly once ch0 becomes valid.
- Assert rst=0 after the 4th word (during the ch2 burst). output_valid falls to 0 immediately and asynchronously. After release, the first output is from ch0 with cnt restarted.
- CHANNELS=1, CHANNEL_COUNTS=8'h04, random valid/ready. Data passes in order; output_last=1 on words 4, 8, 12.
